rh_ahb5_sram_sub: RTL and testbench

Parametrised AHB5 subordinate with an internal SRAM array. It provides configurable wait states, ERROR responses for illegal accesses, and a per-manager exclusive-access monitor driving HEXOKAY. It sits behind the AHB5 interconnect as a bus-functional memory for VIP testbenches, and is the first AHB5 block in the library with real data-phase behaviour rather than bare signal bundling.

---
 rtl/rh_ahb5_sram_sub.sv | 180 ++++++++++++++++++
 tb/tb_rh_ahb5_sram_sub.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rh_ahb5_sram_sub.sv
// rh_ahb5_sram_sub: AHB5 subordinate backed by an internal SRAM, with
// configurable wait states, two-cycle ERROR responses and a per-manager exclusive monitor.
module rh_ahb5_sram_sub #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  parameter int NUM_MASTERS = 4
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic [AW-1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HBURST,
  input  logic [2:0]    HSIZE,
  input  logic [7:0]    HPROT,
  input  logic [3:0]    HMASTER,
  input  logic          HMASTLOCK,
  input  logic          HNONSEC,
  input  logic          HEXCL,
  input  logic          HWRITE,
  input  logic [DW-1:0] HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic [1:0]    HRESP,
  output logic [DW-1:0] HRDATA,
  output logic          HEXOKAY,
  output logic [2:0]    dbg_state
);

  localparam int NB  = DW / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: an address phase is taken on HSEL & HREADY & HTRANS[1] only while
  // no transfer is stalling (IDLE, DATA, ERR2); a transfer completes when HREADYOUT is high in DATA or ERR2.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic          can_accept, accept, legal;
  logic [AW-1:0] word_addr;
  logic [OFF-1:0] align_mask;

  logic [IW-1:0]  reg_idx;
  logic [OFF-1:0] reg_off;
  logic [2:0]     reg_size;
  logic           reg_write, reg_excl;
  logic [3:0]     reg_master;

  logic [DW-1:0] mem [DEPTH];
  logic          ex_valid [NUM_MASTERS];
  logic [IW-1:0] ex_idx   [NUM_MASTERS];

  logic          data_cyc, excl_hit, master_ok, do_write;
  logic [NB-1:0] be;

  logic unused_inputs;
  assign unused_inputs = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK, HNONSEC};

  assign can_accept = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign accept     = can_accept & HSEL & HREADY & HTRANS[1];
  assign word_addr  = HADDR >> OFF;
  assign align_mask = ~({OFF{1'b1}} << HSIZE);
  assign legal      = (word_addr < AW'(DEPTH)) && (HSIZE <= 3'(OFF)) &&
                      ((HADDR[OFF-1:0] & align_mask) == '0);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state      <= S_IDLE;
      cnt        <= '0;
      reg_idx    <= '0;
      reg_off    <= '0;
      reg_size   <= '0;
      reg_write  <= 1'b0;
      reg_excl   <= 1'b0;
      reg_master <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        reg_idx    <= word_addr[IW-1:0];
        reg_off    <= HADDR[OFF-1:0];
        reg_size   <= HSIZE;
        reg_write  <= HWRITE;
        reg_excl   <= HEXCL;
        reg_master <= HMASTER;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (!accept) begin
          state_nxt = S_IDLE;
        end else if (!legal) begin
          state_nxt = S_ERR1;
        end else if (WAIT_STATES > 0) begin
          state_nxt = S_WAIT;
          cnt_nxt   = 4'(WAIT_STATES - 1);
        end else begin
          state_nxt = S_DATA;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nxt = S_DATA;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A manager ID beyond the monitor range never matches, so its exclusives fail.
  always_comb begin
    excl_hit  = 1'b0;
    master_ok = 1'b0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (reg_master == 4'(m)) begin
        master_ok = 1'b1;
        if (ex_valid[m] && (ex_idx[m] == reg_idx)) excl_hit = 1'b1;
      end
    end
  end

  always_comb begin
    be = '0;
    for (int b = 0; b < NB; b++) begin
      if ((b >= int'(reg_off)) && (b < int'(reg_off) + (1 << reg_size))) be[b] = 1'b1;
    end
  end

  assign data_cyc = (state == S_DATA);
  assign do_write = data_cyc && reg_write && (!reg_excl || excl_hit);

  always_ff @(posedge HCLK) begin
    if (do_write) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[reg_idx][b*8 +: 8] <= HWDATA[b*8 +: 8];
      end
    end
  end

  // Any performed write kills every reservation on that word, the writer's own included.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        ex_valid[m] <= 1'b0;
        ex_idx[m]   <= '0;
      end
    end else begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (do_write && (ex_idx[m] == reg_idx)) begin
          ex_valid[m] <= 1'b0;
        end else if (data_cyc && reg_excl && !reg_write && (reg_master == 4'(m))) begin
          ex_valid[m] <= 1'b1;
          ex_idx[m]   <= reg_idx;
        end
      end
    end
  end

  assign HREADYOUT = !((state == S_WAIT) || (state == S_ERR1));
  assign HRESP     = {1'b0, (state == S_ERR1) || (state == S_ERR2)};
  assign HRDATA    = (data_cyc && !reg_write) ? mem[reg_idx] : '0;
  assign HEXOKAY   = data_cyc && reg_excl && (reg_write ? excl_hit : master_ok);
  assign dbg_state = state;

endmodule

// File: tb/tb_rh_ahb5_sram_sub.sv
// tb_rh_ahb5_sram_sub: two instances (zero and three wait states) driven with directed
// and random transfers, checked against a word-array and reservation-table model.
module tb_rh_ahb5_sram_sub;

  localparam int DEPTH = 256;
  localparam int NM    = 4;

  logic clk;
  logic        rst      [2];
  logic        hsel     [2];
  logic [31:0] haddr    [2];
  logic [1:0]  htrans   [2];
  logic [2:0]  hburst   [2];
  logic [2:0]  hsize    [2];
  logic [7:0]  hprot    [2];
  logic [3:0]  hmaster  [2];
  logic        hmastlock[2];
  logic        hnonsec  [2];
  logic        hexcl    [2];
  logic        hwrite   [2];
  logic [31:0] hwdata   [2];
  logic        hready   [2];
  logic        hreadyout[2];
  logic [1:0]  hresp    [2];
  logic [31:0] hrdata   [2];
  logic        hexokay  [2];
  logic [2:0]  dbg_state[2];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mdl  [2][DEPTH];
  bit          ex_v [2][16];
  int          ex_w [2][16];

  rh_ahb5_sram_sub #(.AW(32), .DW(32), .DEPTH(DEPTH), .WAIT_STATES(0), .NUM_MASTERS(NM)) u_dut0 (
    .HCLK(clk), .HRESET(rst[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HBURST(hburst[0]), .HSIZE(hsize[0]), .HPROT(hprot[0]), .HMASTER(hmaster[0]),
    .HMASTLOCK(hmastlock[0]), .HNONSEC(hnonsec[0]), .HEXCL(hexcl[0]), .HWRITE(hwrite[0]),
    .HWDATA(hwdata[0]), .HREADY(hready[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]),
    .HRDATA(hrdata[0]), .HEXOKAY(hexokay[0]), .dbg_state(dbg_state[0]));

  rh_ahb5_sram_sub #(.AW(32), .DW(32), .DEPTH(DEPTH), .WAIT_STATES(3), .NUM_MASTERS(NM)) u_dut1 (
    .HCLK(clk), .HRESET(rst[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HBURST(hburst[1]), .HSIZE(hsize[1]), .HPROT(hprot[1]), .HMASTER(hmaster[1]),
    .HMASTLOCK(hmastlock[1]), .HNONSEC(hnonsec[1]), .HEXCL(hexcl[1]), .HWRITE(hwrite[1]),
    .HWDATA(hwdata[1]), .HREADY(hready[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]),
    .HRDATA(hrdata[1]), .HEXOKAY(hexokay[1]), .dbg_state(dbg_state[1]));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input int d, input string tag);
    check($sformatf("%s d%0d hreadyout", tag, d), hreadyout[d], 1);
    check($sformatf("%s d%0d hresp", tag, d), hresp[d], 0);
    check($sformatf("%s d%0d hrdata", tag, d), hrdata[d], 0);
    check($sformatf("%s d%0d hexokay", tag, d), hexokay[d], 0);
  endtask

  // One non-pipelined transfer; expectations come from the model before it is updated.
  task automatic do_xfer(input int d, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [3:0] mst, input bit excl, input logic [31:0] wdata);
    int idx, off, lat, ws;
    bit legal, ok, exok;
    logic [31:0] exp_rd, w;
    ws     = (d == 0) ? 0 : 3;
    idx    = int'(addr >> 2);
    off    = int'(addr[1:0]);
    legal  = (addr < 32'(DEPTH * 4)) && (size <= 3'd2) && ((addr % (32'd1 << size)) == 0);
    exok   = 1'b0;
    exp_rd = '0;
    if (legal) begin
      if (!wr) begin
        exp_rd = mdl[d][idx];
        if (excl && (mst < NM)) begin
          exok = 1'b1;
          ex_v[d][mst] = 1'b1;
          ex_w[d][mst] = idx;
        end
      end else begin
        ok   = !excl || ((mst < NM) && ex_v[d][mst] && (ex_w[d][mst] == idx));
        exok = excl && ok;
        if (ok) begin
          w = mdl[d][idx];
          for (int b = 0; b < 4; b++)
            if ((b >= off) && (b < off + (1 << size))) w[b*8 +: 8] = wdata[b*8 +: 8];
          mdl[d][idx] = w;
          for (int m = 0; m < 16; m++)
            if (ex_w[d][m] == idx) ex_v[d][m] = 1'b0;
        end
      end
    end
    hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = addr; hsize[d] = size;
    hwrite[d] = wr; hmaster[d] = mst; hexcl[d] = excl; hready[d] = 1'b1;
    @(posedge clk); #1;
    hsel[d] = 1'b0; htrans[d] = 2'b00; hexcl[d] = 1'b0;
    hwdata[d] = wr ? wdata : $urandom;
    lat = legal ? (1 + ws) : 2;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check($sformatf("d%0d a%0h c%0d hreadyout", d, addr, k), hreadyout[d], (k == lat));
      check($sformatf("d%0d a%0h c%0d hresp", d, addr, k), hresp[d], legal ? 64'd0 : 64'd1);
      check($sformatf("d%0d a%0h c%0d hrdata", d, addr, k), hrdata[d],
            (legal && !wr && (k == lat)) ? {32'd0, exp_rd} : 64'd0);
      check($sformatf("d%0d a%0h c%0d hexokay", d, addr, k), hexokay[d], (legal && (k == lat)) ? exok : 1'b0);
      @(posedge clk); #1;
    end
  endtask

  // Write then read the same word with the read address phase overlapping the write data phase.
  task automatic b2b_pair(input logic [31:0] addr, input logic [31:0] data);
    hsel[0] = 1'b1; htrans[0] = 2'b10; haddr[0] = addr; hsize[0] = 3'd2;
    hwrite[0] = 1'b1; hmaster[0] = 4'd0; hexcl[0] = 1'b0; hready[0] = 1'b1;
    @(posedge clk); #1;
    hwdata[0] = data; htrans[0] = 2'b11; hwrite[0] = 1'b0;
    mdl[0][addr >> 2] = data;
    for (int m = 0; m < 16; m++)
      if (ex_w[0][m] == int'(addr >> 2)) ex_v[0][m] = 1'b0;
    @(negedge clk);
    check("b2b wr hreadyout", hreadyout[0], 1);
    check("b2b wr hrdata", hrdata[0], 0);
    @(posedge clk); #1;
    hsel[0] = 1'b0; htrans[0] = 2'b00;
    @(negedge clk);
    check("b2b rd hreadyout", hreadyout[0], 1);
    check("b2b rd hrdata", hrdata[0], mdl[0][addr >> 2]);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    int r, wd;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; hsel[d] = 1'b0; haddr[d] = '0; htrans[d] = '0; hburst[d] = '0;
      hsize[d] = '0; hprot[d] = '0; hmaster[d] = '0; hmastlock[d] = 1'b0; hnonsec[d] = 1'b0;
      hexcl[d] = 1'b0; hwrite[d] = 1'b0; hwdata[d] = '0; hready[d] = 1'b1;
      for (int m = 0; m < 16; m++) begin ex_v[d][m] = 1'b0; ex_w[d][m] = -1; end
    end
    repeat (2) @(negedge clk);
    check_idle_outputs(0, "reset");
    check_idle_outputs(1, "reset");
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) do_xfer(d, 1, 32'(i * 4), 3'd2, 4'd0, 0, $urandom);

    // Zero-wait write/read and back-to-back pipelining
    do_xfer(0, 1, 32'h10, 3'd2, 4'd0, 0, 32'hDEADBEEF);
    do_xfer(0, 0, 32'h10, 3'd2, 4'd0, 0, 32'h0);
    b2b_pair(32'h24, 32'hCAFE0123);
    b2b_pair(32'h28, 32'h5A5AA5A5);

    // Wait states, byte lanes
    do_xfer(1, 0, 32'h30, 3'd2, 4'd0, 0, 32'h0);
    do_xfer(1, 1, 32'h10, 3'd2, 4'd0, 0, 32'h11223344);
    do_xfer(1, 1, 32'h13, 3'd0, 4'd0, 0, 32'hAA000000);
    do_xfer(1, 0, 32'h10, 3'd2, 4'd0, 0, 32'h0);
    do_xfer(1, 1, 32'h16, 3'd1, 4'd0, 0, 32'hBEEF0000);
    do_xfer(1, 0, 32'h14, 3'd2, 4'd0, 0, 32'h0);

    // Illegal accesses leave memory untouched
    do_xfer(1, 1, 32'(DEPTH * 4), 3'd2, 4'd0, 0, 32'h12345678);
    do_xfer(1, 1, 32'h1, 3'd1, 4'd0, 0, 32'hFFFFFFFF);
    do_xfer(1, 1, 32'h0, 3'd3, 4'd0, 0, 32'hFFFFFFFF);
    do_xfer(1, 0, 32'h0, 3'd2, 4'd0, 0, 32'h0);
    do_xfer(0, 1, 32'h2, 3'd2, 4'd0, 0, 32'hFFFFFFFF);
    do_xfer(0, 0, 32'h0, 3'd2, 4'd0, 0, 32'h0);

    // Exclusive sequences on both instances
    for (int d = 0; d < 2; d++) begin
      do_xfer(d, 0, 32'h40, 3'd2, 4'd1, 1, 32'h0);
      do_xfer(d, 1, 32'h40, 3'd2, 4'd1, 1, 32'h600DF00D);
      do_xfer(d, 1, 32'h40, 3'd2, 4'd1, 1, 32'hBAD0BAD0);
      do_xfer(d, 0, 32'h40, 3'd2, 4'd0, 0, 32'h0);
      do_xfer(d, 0, 32'h40, 3'd2, 4'd1, 1, 32'h0);
      do_xfer(d, 1, 32'h40, 3'd2, 4'd2, 0, 32'h22222222);
      do_xfer(d, 1, 32'h40, 3'd2, 4'd1, 1, 32'h11111111);
      do_xfer(d, 0, 32'h40, 3'd2, 4'd0, 0, 32'h0);
      do_xfer(d, 0, 32'h44, 3'd2, 4'd7, 1, 32'h0);
      do_xfer(d, 1, 32'h44, 3'd2, 4'd7, 1, 32'h77777777);
      do_xfer(d, 0, 32'h44, 3'd2, 4'd0, 0, 32'h0);
    end

    // BUSY with HSEL, and an address phase with HREADY low, are both ignored
    hsel[1] = 1'b1; htrans[1] = 2'b01;
    @(posedge clk); #1;
    hsel[1] = 1'b0; htrans[1] = 2'b00;
    @(negedge clk);
    check("busy hreadyout", hreadyout[1], 1);
    check("busy hresp", hresp[1], 0);
    @(posedge clk); #1;
    hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h10; hwrite[1] = 1'b1; hready[1] = 1'b0;
    @(posedge clk); #1;
    hsel[1] = 1'b0; htrans[1] = 2'b00; hready[1] = 1'b1;
    @(negedge clk);
    check("hready low ignored", hreadyout[1], 1);
    @(posedge clk); #1;

    // Reset during the wait of a write drops the write
    do_xfer(1, 1, 32'h20, 3'd2, 4'd0, 0, 32'h0BADF00D);
    do_xfer(1, 0, 32'h20, 3'd2, 4'd3, 1, 32'h0);
    hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h20; hsize[1] = 3'd2;
    hwrite[1] = 1'b1; hmaster[1] = 4'd0; hexcl[1] = 1'b0;
    @(posedge clk); #1;
    hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 32'h12345678;
    @(negedge clk);
    check("rst wait hreadyout", hreadyout[1], 0);
    rst[1] = 1'b1;
    #1;
    check_idle_outputs(1, "rst mid");
    @(posedge clk); #1;
    rst[1] = 1'b0;
    for (int m = 0; m < 16; m++) ex_v[1][m] = 1'b0;
    @(posedge clk); #1;
    do_xfer(1, 0, 32'h20, 3'd2, 4'd0, 0, 32'h0);
    do_xfer(1, 1, 32'h20, 3'd2, 4'd3, 1, 32'hEEEEEEEE);
    do_xfer(1, 0, 32'h20, 3'd2, 4'd0, 0, 32'h0);

    // Random traffic
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 150; i++) begin
        r = int'($urandom_range(0, 19));
        if (r == 0) begin
          a = 32'(DEPTH * 4) + 32'($urandom_range(0, 63) * 4); sz = 3'd2;
        end else if (r == 1) begin
          a = 32'($urandom_range(0, 63) * 4); sz = 3'd3;
        end else if (r == 2) begin
          a = 32'($urandom_range(0, 255)); sz = 3'($urandom_range(0, 2));
        end else begin
          sz = 3'($urandom_range(0, 2));
          wd = int'($urandom_range(0, (r < 12) ? 7 : 63));
          a  = 32'(wd * 4) + (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 1));
        end
        do_xfer(d, bit'($urandom_range(0, 1)), a, sz, 4'($urandom_range(0, 5)),
                ($urandom_range(0, 2) == 0), $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
